maze_write_buffer: RTL and testbench
====================================

MAZE_WRITE_BUFFER -- requirements
Module: maze_write_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered line writes (power of two, >=2).
REQ-002 SHALL have parameter ADDR_W, default 12, line-address width.
REQ-003 SHALL have parameter DATA_W, default 128, line data width.
REQ-004 SHALL have parameter SEL_W, default 16, byte-select width (DATA_W/8).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 c_cyc, c_stb, c_we  in  1 each  wishbone request from L1 data cache.
REQ-008 c_adr  in  ADDR_W;  c_sel  in  SEL_W;  c_dat_w  in  DATA_W  cache request address, byte enables, write data.
REQ-009 c_dat_r  out  DATA_W;  c_ack  out  1  read data and acknowledge to cache.
REQ-010 m_cyc, m_stb, m_we  out  1 each  wishbone request to interconnect.
REQ-011 m_adr  out  ADDR_W;  m_sel  out  SEL_W;  m_dat_w  out  DATA_W  downstream address, byte enables, write data.
REQ-012 m_dat_r  in  DATA_W;  m_ack, m_rty  in  1 each  downstream read data, acknowledge, retry.
REQ-013 empty  out  1  high when no entry is buffered and no downstream transaction is in flight.

Function
REQ-014 Buffer SHALL be a DEPTH-entry circular FIFO of {adr, sel, data}, head/tail pointers wrapping modulo DEPTH, count 0..DEPTH.
REQ-015 Request SHALL be sampled only on cycles where c_cyc&c_stb=1 and c_ack=0; c_ack SHALL be registered and high exactly one cycle per accepted request.
REQ-016 Write, count<DEPTH: sampled cycle N -> c_ack=1 in N+1, entry visible in N+1; accepted in any FSM state.
REQ-017 Write whose c_adr equals a buffered, non-in-flight entry SHALL coalesce: bytes with c_sel=1 overwrite, entry sel |= c_sel, count unchanged, c_ack in N+1; coalescing allowed at count=DEPTH.
REQ-018 Write matching the entry in flight (DRAIN) SHALL NOT coalesce; it allocates a new entry.
REQ-019 Write, count=DEPTH, no coalesce: no ack; retried each cycle; same-cycle pop SHALL NOT enable acceptance (full decided on registered count).
REQ-020 FSM states IDLE, DRAIN, READ; exactly one downstream transaction outstanding.
REQ-021 IDLE -> READ: pending read whose c_adr matches no buffered entry; read SHALL have priority over draining.
REQ-022 IDLE -> DRAIN: count>0 and no READ-eligible read (includes read blocked by address match, which drains until no match).
REQ-023 DRAIN SHALL drive m_cyc=m_stb=m_we=1 with head adr/sel/data, held stable until m_ack; on m_ack pop head, return to IDLE.
REQ-024 READ SHALL drive m_cyc=m_stb=1, m_we=0, m_sel=all ones, m_adr=c_adr; on m_ack latch m_dat_r into c_dat_r, c_ack=1 next cycle, return to IDLE.
REQ-025 m_rty in DRAIN/READ SHALL drop m_stb and m_cyc for one cycle then reissue identical request; no pop, no cache ack.
REQ-026 m_ack and m_rty together: m_ack SHALL win.
REQ-027 Read latency SHALL be downstream ack latency + 1 cycle, plus drain time of address-matching entries.
REQ-028 Outside DRAIN/READ, m_cyc and m_stb SHALL be 0; m_adr/m_dat_w/m_sel don't-care.

Reset
REQ-029 rst SHALL immediately clear count, head, tail, all entry sel bits, FSM=IDLE, c_ack=0, m_cyc=m_stb=m_we=0, c_dat_r=0, empty=1.
REQ-030 Reset mid-transaction SHALL abandon in-flight downstream request and discard all buffered writes; a late m_ack after reset SHALL be ignored.

Verification
REQ-031 Single write adr=0x010, sel=0xFFFF, data=D0, m_ack 2 cycles after m_stb -> c_ack cycle N+1; DRAIN issues adr 0x010/D0; empty=1 after m_ack.
REQ-032 Fill: 4 writes adr 0x001..0x004, m_ack held low -> 4 acks, fifth write (0x005) unacked until first m_ack, then acked; drain order 0x001..0x005.
REQ-033 Coalesce: write 0x020 sel=0x00FF data A, then 0x020 sel=0xFF00 data B while not in flight -> one entry, sel=0xFFFF, low bytes A / high bytes B.
REQ-034 Read hazard: buffered write 0x030, read 0x030 -> write drained first, then read issued m_we=0; c_ack returns m_dat_r one cycle after m_ack.
REQ-035 Retry: m_rty on a drain -> m_stb low one cycle, identical reissue, entry popped only on m_ack.
REQ-036 Reset with 3 entries and DRAIN in flight -> all outputs at reset values same cycle, empty=1, subsequent m_ack ignored.

Source files
------------

// File: rtl/maze_write_buffer.sv
// maze_write_buffer: coalescing write buffer between an L1 data cache and a wishbone interconnect.
// Reads bypass the buffer unless their address is buffered, in which case the buffer drains first.
module maze_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 128,
  parameter int SEL_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              c_cyc,
  input  logic              c_stb,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_adr,
  input  logic [SEL_W-1:0]  c_sel,
  input  logic [DATA_W-1:0] c_dat_w,
  output logic [DATA_W-1:0] c_dat_r,
  output logic              c_ack,
  output logic              m_cyc,
  output logic              m_stb,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_adr,
  output logic [SEL_W-1:0]  m_sel,
  output logic [DATA_W-1:0] m_dat_w,
  input  logic [DATA_W-1:0] m_dat_r,
  input  logic              m_ack,
  input  logic              m_rty,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_t;
  state_t            r_state;
  logic [ADDR_W-1:0] r_adr [DEPTH];
  logic [SEL_W-1:0]  r_sel [DEPTH];
  logic [DATA_W-1:0] r_dat [DEPTH];
  logic [PW-1:0]     r_head, r_tail;
  logic [PW:0]       r_count;
  logic              r_mreq;
  logic              w_req, w_wr, w_rd, w_hit, w_rd_hit, w_push, w_pop;
  logic [PW-1:0]     w_hit_idx, w_idx;
  // w_hit excludes the in-flight head so a write never alters data already on the bus
  always_comb begin
    w_hit = 1'b0;
    w_rd_hit = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (({1'b0, PW'(i) - r_head} < r_count) && r_adr[i] == c_adr) begin
        w_rd_hit = 1'b1;
        if (!(r_state == DRAIN && PW'(i) == r_head)) begin
          w_hit = 1'b1;
          w_hit_idx = PW'(i);
        end
      end
    end
  end
  assign w_req   = c_cyc & c_stb & ~c_ack;
  assign w_wr    = w_req & c_we & (w_hit | (r_count != (PW+1)'(DEPTH)));
  assign w_rd    = w_req & ~c_we;
  assign w_push  = w_wr & ~w_hit;
  assign w_pop   = (r_state == DRAIN) & r_mreq & m_ack;
  assign w_idx   = w_hit ? w_hit_idx : r_tail;
  assign m_cyc   = r_mreq;
  assign m_stb   = r_mreq;
  assign m_we    = r_mreq & (r_state == DRAIN);
  assign m_adr   = (r_state == DRAIN) ? r_adr[r_head] : c_adr;
  assign m_sel   = (r_state == DRAIN) ? r_sel[r_head] : '1;
  assign m_dat_w = r_dat[r_head];
  assign empty   = (r_count == '0) && (r_state == IDLE);
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_adr[w_idx] <= c_adr;
      for (int b = 0; b < SEL_W; b++)
        if (c_sel[b]) r_dat[w_idx][8*b +: 8] <= c_dat_w[8*b +: 8];
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_sel[i] <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_state <= IDLE;
      r_mreq  <= 1'b0;
      c_ack   <= 1'b0;
      c_dat_r <= '0;
    end else begin
      if (w_wr) r_sel[w_idx] <= (w_hit ? r_sel[w_idx] : '0) | c_sel;
      r_tail  <= r_tail + PW'(w_push);
      r_head  <= r_head + PW'(w_pop);
      r_count <= r_count + (PW+1)'(w_push) - (PW+1)'(w_pop);
      c_ack   <= w_wr | ((r_state == READ) & r_mreq & m_ack);
      if (r_state == IDLE) begin
        if (w_rd && !w_rd_hit) begin
          r_state <= READ;
          r_mreq  <= 1'b1;
        end else if (r_count != '0) begin
          r_state <= DRAIN;
          r_mreq  <= 1'b1;
        end
      end else if (r_mreq && m_ack) begin
        if (r_state == READ) c_dat_r <= m_dat_r;
        r_state <= IDLE;
        r_mreq  <= 1'b0;
      end else begin
        r_mreq <= !(r_mreq && m_rty);
      end
    end
  end
endmodule

// File: tb/tb_maze_write_buffer.sv
// tb_maze_write_buffer: directed scoreboard bench; a background slave acks/retries downstream
// transactions and checks drains against the expected-write queue.
module tb_maze_write_buffer;
  typedef struct packed {logic [11:0] adr; logic [15:0] sel; logic [127:0] dat;} wr_t;
  logic clk = 0, rst = 1;
  logic c_cyc = 0, c_stb = 0, c_we = 0;
  logic [11:0] c_adr = '0;
  logic [15:0] c_sel = '0;
  logic [127:0] c_dat_w = '0, c_dat_r, m_dat_w, m_dat_r;
  logic c_ack, m_cyc, m_stb, m_we, m_ack, m_rty, empty;
  logic [11:0] m_adr;
  logic [15:0] m_sel;
  int n_tests = 0, n_fail = 0, n_rty = 0;
  wr_t wq[$];
  logic [127:0] rq[$];
  logic slave_go = 0, rty_pending = 0, late_ack = 0, got;
  int ack_lat = 2, rty_chk = 0;
  logic [11:0] rty_adr, rd_adr;
  logic [127:0] rty_dat, rd_data, exp_d, a_dat, b_dat;
  time ack_t = 0;

  maze_write_buffer dut (
    .clk(clk), .rst(rst), .c_cyc(c_cyc), .c_stb(c_stb), .c_we(c_we), .c_adr(c_adr),
    .c_sel(c_sel), .c_dat_w(c_dat_w), .c_dat_r(c_dat_r), .c_ack(c_ack), .m_cyc(m_cyc),
    .m_stb(m_stb), .m_we(m_we), .m_adr(m_adr), .m_sel(m_sel), .m_dat_w(m_dat_w),
    .m_dat_r(m_dat_r), .m_ack(m_ack), .m_rty(m_rty), .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input logic [11:0] adr);
    return {4{20'hCAFE0, adr}};
  endfunction

  task automatic wr(input logic [11:0] adr, input logic [15:0] sel, input logic [127:0] dat);
    c_cyc = 1; c_stb = 1; c_we = 1; c_adr = adr; c_sel = sel; c_dat_w = dat;
    cyc();
    chk("wr_ack", c_ack, 1'b1);
    c_cyc = 0; c_stb = 0; c_we = 0;
    cyc();
    chk("wr_ack_pulse", c_ack, 1'b0);
  endtask

  task automatic wait_ack(input int max, output logic g);
    g = 0;
    for (int i = 0; i < max && !g; i++) begin
      cyc();
      if (c_ack) g = 1;
    end
  endtask

  task automatic wait_empty(input string tag, input int max);
    for (int i = 0; i < max && !empty; i++) cyc();
    chk(tag, empty, 1'b1);
  endtask

  // downstream slave: acks after ack_lat stb cycles, optionally retries once
  initial begin
    int cnt = 0;
    wr_t e;
    m_ack = 0; m_rty = 0; m_dat_r = '0;
    forever begin
      cyc();
      m_ack = 0; m_rty = 0;
      if (rty_chk == 1) begin
        chk("rty_drop", m_stb, 1'b0);
        rty_chk = 2;
      end else if (rty_chk == 2) begin
        chk("rty_reissue", {m_stb, m_we, m_adr, m_dat_w}, {1'b1, 1'b1, rty_adr, rty_dat});
        rty_chk = 0;
      end
      if (late_ack) begin
        m_ack = 1;
        late_ack = 0;
      end else if (!rst && m_cyc && m_stb && slave_go) begin
        cnt++;
        if (cnt >= ack_lat) begin
          cnt = 0;
          if (rty_pending) begin
            m_rty = 1; rty_pending = 0; n_rty++; rty_chk = 1;
            rty_adr = m_adr; rty_dat = m_dat_w;
          end else begin
            m_ack = 1;
            ack_t = $time;
            if (m_we) begin
              chk("drain_expected", wq.size() != 0, 1'b1);
              if (wq.size() != 0) begin
                e = wq.pop_front();
                chk("drain_txn", {m_adr, m_sel, m_dat_w}, e);
              end
            end else begin
              chk("rd_after_drain", wq.size(), 0);
              chk("rd_req", {m_adr, m_sel}, {rd_adr, 16'hFFFF});
              m_dat_r = rd_data;
            end
          end
        end
      end else cnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    cyc();
    chk("rst_outs", {c_ack, m_cyc, m_stb, m_we, empty}, 5'b00001);
    chk("rst_dat_r", c_dat_r, 128'h0);
    cyc();
    rst = 0;
    slave_go = 1;
    // single write, ack two cycles after stb
    wq.push_back('{12'h010, 16'hFFFF, mk(12'h010)});
    wr(12'h010, 16'hFFFF, mk(12'h010));
    chk("t1_busy", empty, 1'b0);
    wait_empty("t1_empty", 20);
    chk("t1_sb", wq.size(), 0);
    // fill to DEPTH with downstream stalled
    slave_go = 0;
    for (int i = 1; i <= 4; i++) begin
      wq.push_back('{12'(i), 16'hFFFF, mk(12'(i))});
      wr(12'(i), 16'hFFFF, mk(12'(i)));
    end
    wq.push_back('{12'h005, 16'hFFFF, mk(12'h005)});
    c_cyc = 1; c_stb = 1; c_we = 1; c_adr = 12'h005; c_sel = 16'hFFFF; c_dat_w = mk(12'h005);
    got = 0;
    for (int i = 0; i < 6; i++) begin
      cyc();
      if (c_ack) got = 1;
    end
    chk("full_no_ack", got, 1'b0);
    slave_go = 1;
    wait_ack(20, got);
    chk("full_ack_after_pop", got, 1'b1);
    c_cyc = 0; c_stb = 0; c_we = 0;
    cyc();
    wait_empty("t2_empty", 60);
    chk("t2_sb", wq.size(), 0);
    // coalesce into a non-in-flight entry; same-address write behind the in-flight head allocates
    slave_go = 0;
    a_dat = {4{32'hAAAA_AAAA}};
    b_dat = {4{32'hBBBB_BBBB}};
    exp_d = {b_dat[127:64], a_dat[63:0]};
    wq.push_back('{12'h040, 16'hFFFF, mk(12'h040)});
    wq.push_back('{12'h020, 16'hFFFF, exp_d});
    wq.push_back('{12'h040, 16'hFFFF, mk(12'h041)});
    wr(12'h040, 16'hFFFF, mk(12'h040));
    chk("t3_inflight", {m_cyc, m_we, m_adr}, {1'b1, 1'b1, 12'h040});
    wr(12'h020, 16'h00FF, a_dat);
    wr(12'h040, 16'hFFFF, mk(12'h041));
    wr(12'h020, 16'hFF00, b_dat);
    slave_go = 1;
    wait_empty("t3_empty", 60);
    chk("t3_sb", wq.size(), 0);
    // read hazard: buffered write to same address drains before the read
    slave_go = 0;
    wq.push_back('{12'h030, 16'hFFFF, mk(12'h030)});
    wr(12'h030, 16'hFFFF, mk(12'h030));
    rd_adr = 12'h030;
    rd_data = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rq.push_back(rd_data);
    c_cyc = 1; c_stb = 1; c_we = 0; c_adr = 12'h030;
    slave_go = 1;
    wait_ack(40, got);
    chk("rd_ack", got, 1'b1);
    chk("rd_latency", $time - ack_t, 10);
    if (rq.size() != 0) chk("rd_data", c_dat_r, rq.pop_front());
    c_cyc = 0; c_stb = 0;
    cyc();
    chk("rd_ack_pulse", c_ack, 1'b0);
    wait_empty("t4_empty", 20);
    // retry on a drain
    rty_pending = 1;
    wq.push_back('{12'h050, 16'hFFFF, mk(12'h050)});
    wr(12'h050, 16'hFFFF, mk(12'h050));
    wait_empty("t5_empty", 40);
    chk("t5_rty_cnt", n_rty, 1);
    chk("t5_sb", wq.size(), 0);
    // reset with three entries and a drain in flight
    slave_go = 0;
    wr(12'h061, 16'hFFFF, mk(12'h061));
    wr(12'h062, 16'hFFFF, mk(12'h062));
    wr(12'h063, 16'hFFFF, mk(12'h063));
    chk("t6_inflight", m_cyc, 1'b1);
    #2 rst = 1;
    #1;
    chk("t6_rst_outs", {c_ack, m_cyc, m_stb, m_we, empty}, 5'b00001);
    chk("t6_rst_dat_r", c_dat_r, 128'h0);
    cyc();
    cyc();
    rst = 0;
    late_ack = 1;
    for (int i = 0; i < 4; i++) cyc();
    chk("t6_late_ack", {c_ack, m_cyc, empty}, 3'b001);
    slave_go = 1;
    wq.push_back('{12'h070, 16'hFFFF, mk(12'h070)});
    wr(12'h070, 16'hFFFF, mk(12'h070));
    wait_empty("t6_empty", 20);
    chk("final_sb", wq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
